// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit scheduler: FSM states,
// the voice packet descriptor and default address / PDU sizing.
package eth_pkg;

  localparam int unsigned ETH_ADDR_WIDTH = 13;
  localparam int unsigned ETH_MAX_PDU    = 1500;
  localparam int unsigned ETH_CTL_LEN_W  = $clog2(ETH_MAX_PDU + 1);
  localparam int unsigned ETH_ID_W       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } tx_state_t;

  typedef struct packed {
    logic [ETH_ADDR_WIDTH-1:0] end_addr;
    logic [ETH_ID_W-1:0]       ident;
    logic [ETH_ID_W-1:0]       idx;
  } eth_desc_t;

endpackage

// File: rtl/eth_tx_sched_ring.sv
// Descriptor ring for closed voice packets: power-of-two FIFO with
// registered full/empty flags and a combinational head view.
module eth_desc_ring
  import eth_pkg::*;
#(
  parameter int unsigned DESC_LOG2 = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  eth_desc_t push_desc,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output eth_desc_t head_c
);

  localparam int unsigned PTR_W = DESC_LOG2 + 1;
  localparam int unsigned DEPTH = 2 ** DESC_LOG2;

  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W-1:0] wptr_d, rptr_d;
  logic             push_ok, pop_ok;
  eth_desc_t        mem [DEPTH];

  // A push against a full ring is dropped even when a pop retires a slot
  // in the same cycle, because only the registered flag is consulted.
  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    wptr_d  = wptr + PTR_W'(push_ok);
    rptr_d  = rptr + PTR_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wptr  <= wptr_d;
      rptr  <= rptr_d;
      empty <= (wptr_d == rptr_d);
      full  <= (wptr_d == {~rptr_d[PTR_W-1], rptr_d[PTR_W-2:0]});
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr[PTR_W-2:0]] <= push_desc;
    end
  end

  assign head_c = mem[rptr[PTR_W-2:0]];

endmodule

// File: rtl/eth_tx_sched.sv
// Transmit scheduler: alternates control replies with queued voice packets and
// hands one frame at a time to the transmitter. Optional send watchdog is
// enabled by defining ETH_TX_SCHED_TIMEOUT_EN.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ETH_ADDR_WIDTH,
  parameter int unsigned DESC_LOG2      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [ADDR_WIDTH-1:0]    i_push_end,
  input  logic [15:0]              i_push_id,
  output logic                     o_full,
  output logic                     o_empty,
  input  logic                     i_ctl_req,
  input  logic [ETH_CTL_LEN_W-1:0] i_ctl_len,
  output logic                     o_ctl_gnt,
  output logic                     o_trig_send,
  output logic [ADDR_WIDTH-1:0]    o_data_st,
  output logic [ADDR_WIDTH-1:0]    o_data_end,
  output logic [ETH_ID_W-1:0]      o_pck_ident,
  output logic [ETH_ID_W-1:0]      o_pck_idx,
  output logic                     o_sel_ctl,
  input  logic                     i_send_over,
  output logic                     o_release,
  output logic                     o_timeout
);

  if (ADDR_WIDTH > ETH_ADDR_WIDTH || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("eth_tx_sched: unsupported ADDR_WIDTH or TIMEOUT_CYCLES");
  end

  tx_state_t             state, state_d;
  logic [ADDR_WIDTH-1:0] start_addr, start_addr_d;
  logic                  last_ctl, last_ctl_d;
  logic                  trig_d, gnt_d, rel_d, sel_ctl_d;
  logic [ADDR_WIDTH-1:0] data_st_d, data_end_d;
  logic [ETH_ID_W-1:0]   ident_d, idx_d;
  logic                  pop;
  logic                  expire;
  logic                  frame_done;
  eth_desc_t             push_desc, head;

  assign push_desc = '{end_addr: ETH_ADDR_WIDTH'(i_push_end),
                       ident:    i_push_id[15:8],
                       idx:      i_push_id[7:0]};

  eth_desc_ring #(
    .DESC_LOG2 (DESC_LOG2)
  ) u_ring (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (i_push),
    .push_desc (push_desc),
    .pop       (pop),
    .full      (o_full),
    .empty     (o_empty),
    .head_c    (head)
  );

  assign frame_done = i_send_over || expire;

  // Next-state and launch/retire decisions.
  always_comb begin
    state_d      = state;
    start_addr_d = start_addr;
    last_ctl_d   = last_ctl;
    trig_d       = 1'b0;
    gnt_d        = 1'b0;
    rel_d        = 1'b0;
    pop          = 1'b0;
    data_st_d    = o_data_st;
    data_end_d   = o_data_end;
    ident_d      = o_pck_ident;
    idx_d        = o_pck_idx;
    sel_ctl_d    = o_sel_ctl;

    case (state)
      IDLE: begin
        // Control wins unless it also won last time and voice is waiting.
        if (i_ctl_req && (!last_ctl || o_empty)) begin
          data_st_d  = '0;
          data_end_d = ADDR_WIDTH'(i_ctl_len);
          ident_d    = '0;
          idx_d      = '0;
          sel_ctl_d  = 1'b1;
          gnt_d      = 1'b1;
          trig_d     = 1'b1;
          last_ctl_d = 1'b1;
          state_d    = LAUNCH;
        end else if (!o_empty) begin
          data_st_d  = start_addr;
          data_end_d = ADDR_WIDTH'(head.end_addr);
          ident_d    = head.ident;
          idx_d      = head.idx;
          sel_ctl_d  = 1'b0;
          trig_d     = 1'b1;
          last_ctl_d = 1'b0;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (frame_done) begin
          state_d = IDLE;
          if (!o_sel_ctl) begin
            pop          = 1'b1;
            start_addr_d = o_data_end;
            rel_d        = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      start_addr  <= '0;
      last_ctl    <= 1'b0;
      o_trig_send <= 1'b0;
      o_ctl_gnt   <= 1'b0;
      o_release   <= 1'b0;
      o_data_st   <= '0;
      o_data_end  <= '0;
      o_pck_ident <= '0;
      o_pck_idx   <= '0;
      o_sel_ctl   <= 1'b0;
    end else begin
      state       <= state_d;
      start_addr  <= start_addr_d;
      last_ctl    <= last_ctl_d;
      o_trig_send <= trig_d;
      o_ctl_gnt   <= gnt_d;
      o_release   <= rel_d;
      o_data_st   <= data_st_d;
      o_data_end  <= data_end_d;
      o_pck_ident <= ident_d;
      o_pck_idx   <= idx_d;
      o_sel_ctl   <= sel_ctl_d;
    end
  end

`ifdef ETH_TX_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;

  // Counter holds the number of completed WAIT cycles; expiry on the last one.
  assign expire = (state == WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      wd_cnt    <= (state == WAIT && state_d == WAIT) ? wd_cnt + WD_W'(1) : '0;
      o_timeout <= expire && !i_send_over;
    end
  end
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: launch latency, ring full/drop, control
// arbitration, address wrap, reset mid-frame and the optional watchdog.
module tb_eth_tx_sched;

  localparam int unsigned AW = 13;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_push;
  logic [AW-1:0] i_push_end;
  logic [15:0]   i_push_id;
  logic          o_full, o_empty;
  logic          i_ctl_req;
  logic [10:0]   i_ctl_len;
  logic          o_ctl_gnt, o_trig_send;
  logic [AW-1:0] o_data_st, o_data_end;
  logic [7:0]    o_pck_ident, o_pck_idx;
  logic          o_sel_ctl;
  logic          i_send_over;
  logic          o_release, o_timeout;

  int n_total = 0;
  int n_pass  = 0;

  eth_tx_sched #(
    .ADDR_WIDTH     (AW),
    .DESC_LOG2      (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (i_push),
    .i_push_end  (i_push_end),
    .i_push_id   (i_push_id),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .i_ctl_req   (i_ctl_req),
    .i_ctl_len   (i_ctl_len),
    .o_ctl_gnt   (o_ctl_gnt),
    .o_trig_send (o_trig_send),
    .o_data_st   (o_data_st),
    .o_data_end  (o_data_end),
    .o_pck_ident (o_pck_ident),
    .o_pck_idx   (o_pck_idx),
    .o_sel_ctl   (o_sel_ctl),
    .i_send_over (i_send_over),
    .o_release   (o_release),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Entered on a falling edge; push is sampled at the next rising edge.
  task automatic push(input logic [AW-1:0] e, input logic [15:0] id);
    i_push     = 1'b1;
    i_push_end = e;
    i_push_id  = id;
    @(negedge i_clk);
    i_push     = 1'b0;
  endtask

  task automatic wait_trig(input string tag);
    int n = 0;
    while (o_trig_send !== 1'b1 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, 32'(o_trig_send), 32'd1);
  endtask

  // Called in the LAUNCH cycle: step into WAIT, then complete the frame.
  task automatic serve(input string tag, input logic exp_rel);
    @(negedge i_clk);
    i_send_over = 1'b1;
    @(negedge i_clk);
    i_send_over = 1'b0;
    chk(tag, 32'(o_release), 32'(exp_rel));
  endtask

  task automatic chk_frame(input string tag, input logic [AW-1:0] st, input logic [AW-1:0] en,
                           input logic sel);
    chk({tag, "_st"},  32'(o_data_st),  32'(st));
    chk({tag, "_end"}, 32'(o_data_end), 32'(en));
    chk({tag, "_sel"}, 32'(o_sel_ctl),  32'(sel));
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_push      = 1'b0;
    i_push_end  = '0;
    i_push_id   = '0;
    i_ctl_req   = 1'b0;
    i_ctl_len   = '0;
    i_send_over = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full",  32'(o_full),  32'd0);
    chk("rst_trig",  32'(o_trig_send), 32'd0);
    chk("rst_end",   32'(o_data_end), 32'd0);
    chk("rst_sel",   32'(o_sel_ctl), 32'd0);
    chk("rst_tmo",   32'(o_timeout), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Single voice packet: trigger two cycles after the push cycle.
    push(13'd1470, 16'h0100);
    chk("lat_trig_early", 32'(o_trig_send), 32'd0);
    @(negedge i_clk);
    chk("lat_trig", 32'(o_trig_send), 32'd1);
    chk_frame("v1", 13'd0, 13'd1470, 1'b0);
    chk("v1_ident", 32'(o_pck_ident), 32'h01);
    chk("v1_idx",   32'(o_pck_idx),   32'h00);
    i_send_over = 1'b1;
    @(negedge i_clk);
    i_send_over = 1'b0;
    chk("launch_sendover_ignored", 32'(o_release), 32'd0);
    chk("trig_one_cycle", 32'(o_trig_send), 32'd0);
    i_send_over = 1'b1;
    @(negedge i_clk);
    i_send_over = 1'b0;
    chk("v1_release", 32'(o_release), 32'd1);
    chk("v1_empty",   32'(o_empty),   32'd1);
    push(13'd3000, 16'h0101);
    wait_trig("v2_trig");
    chk_frame("v2", 13'd1470, 13'd3000, 1'b0);
    serve("v2_release", 1'b1);

    // Fill the ring: four accepted, fifth dropped.
    for (int i = 1; i <= 4; i++) begin
      push(AW'(100 * i), 16'(i));
    end
    chk("fill_full", 32'(o_full), 32'd1);
    push(13'd500, 16'h0005);
    chk("fill_still_full", 32'(o_full), 32'd1);
    chk_frame("f1", 13'd3000, 13'd100, 1'b0);
    i_send_over = 1'b1;
    @(negedge i_clk);
    i_send_over = 1'b0;
    chk("f1_release", 32'(o_release), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      wait_trig("fn_trig");
      chk_frame("fn", AW'(100 * (i - 1)), AW'(100 * i), 1'b0);
      chk("fn_idx", 32'(o_pck_idx), 32'(i));
      serve("fn_release", 1'b1);
    end
    chk("fill_drained", 32'(o_empty), 32'd1);
    repeat (4) @(negedge i_clk);
    chk("fifth_dropped", 32'(o_trig_send), 32'd0);

    // Control held high with two voice packets queued: strict alternation.
    i_ctl_req = 1'b1;
    i_ctl_len = 11'd64;
    push(13'd1000, 16'h0A0A);
    chk("c1_trig", 32'(o_trig_send), 32'd1);
    chk("c1_gnt",  32'(o_ctl_gnt),   32'd1);
    chk_frame("c1", 13'd0, 13'd64, 1'b1);
    i_push     = 1'b1;
    i_push_end = 13'd1100;
    i_push_id  = 16'h0B0B;
    @(negedge i_clk);
    i_push = 1'b0;
    i_send_over = 1'b1;
    @(negedge i_clk);
    i_send_over = 1'b0;
    chk("c1_no_release", 32'(o_release), 32'd0);
    wait_trig("a_trig");
    chk("a_gnt", 32'(o_ctl_gnt), 32'd0);
    chk_frame("a", 13'd400, 13'd1000, 1'b0);
    serve("a_release", 1'b1);
    wait_trig("c2_trig");
    chk_frame("c2", 13'd0, 13'd64, 1'b1);
    serve("c2_no_release", 1'b0);
    wait_trig("b_trig");
    i_ctl_req = 1'b0;
    chk_frame("b", 13'd1000, 13'd1100, 1'b0);
    chk("b_idx", 32'(o_pck_idx), 32'h0B);
    serve("b_release", 1'b1);

    // Buffer address wrap.
    push(13'd8100, 16'h0C00);
    wait_trig("w1_trig");
    chk_frame("w1", 13'd1100, 13'd8100, 1'b0);
    serve("w1_release", 1'b1);
    push(13'd200, 16'h0C01);
    wait_trig("w2_trig");
    chk_frame("w2", 13'd8100, 13'd200, 1'b0);
    serve("w2_release", 1'b1);

    // Reset during WAIT with a second descriptor still queued.
    push(13'd500, 16'h0D01);
    push(13'd600, 16'h0D02);
    wait_trig("r_trig");
    chk_frame("r", 13'd200, 13'd500, 1'b0);
    @(negedge i_clk);
`ifndef ETH_TX_SCHED_TIMEOUT_EN
    repeat (20) @(negedge i_clk);
    chk("wait_forever_rel", 32'(o_release), 32'd0);
    chk("wait_forever_tmo", 32'(o_timeout), 32'd0);
`endif
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("mid_rst_empty", 32'(o_empty),   32'd1);
    chk("mid_rst_rel",   32'(o_release), 32'd0);
    chk("mid_rst_end",   32'(o_data_end), 32'd0);
    i_send_over = 1'b1;
    @(negedge i_clk);
    i_send_over = 1'b0;
    chk("post_rst_sendover_rel", 32'(o_release), 32'd0);
    repeat (3) @(negedge i_clk);
    chk("post_rst_no_trig", 32'(o_trig_send), 32'd0);
    chk("post_rst_empty", 32'(o_empty), 32'd1);
    push(13'd50, 16'h0203);
    wait_trig("p_trig");
    chk_frame("p", 13'd0, 13'd50, 1'b0);
    chk("p_ident", 32'(o_pck_ident), 32'h02);
    chk("p_idx",   32'(o_pck_idx),   32'h03);
    serve("p_release", 1'b1);

`ifdef ETH_TX_SCHED_TIMEOUT_EN
    // Watchdog: sixteen WAIT cycles without send_over.
    push(13'd700, 16'h0E00);
    wait_trig("t_trig");
    repeat (16) @(negedge i_clk);
    chk("t_not_yet", 32'(o_timeout), 32'd0);
    @(negedge i_clk);
    chk("t_timeout", 32'(o_timeout), 32'd1);
    chk("t_release", 32'(o_release), 32'd1);
    chk("t_empty",   32'(o_empty),   32'd1);
    @(negedge i_clk);
    chk("t_pulse", 32'(o_timeout), 32'd0);
    push(13'd900, 16'h0E01);
    wait_trig("t2_trig");
    chk_frame("t2", 13'd700, 13'd900, 1'b0);
    serve("t2_release", 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
